// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display reads win on active strobes, buffered
// UART writes fill the free slots, read data returns with a fixed 2-edge latency.
module vga_fb_arbiter #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 12,
  parameter bit VBLANK_ONLY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_ce,
  input  logic              disp_active,
  input  logic              vblank,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_pixel,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  output logic [15:0]       stall_cnt,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    TAG_IDLE,
    TAG_RD,
    TAG_BLANK,
    TAG_WR
  } tag_e;

  logic              wr_ready_q, wr_ready_d;
  logic              hold_full_q, hold_full_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  tag_e              tag0_q, tag0_d;
  tag_e              tag1_q, tag1_d;
  logic [DATA_W-1:0] disp_pixel_q, disp_pixel_d;
  logic              wr_done_q, wr_done_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic accept;
  logic rd_slot;
  logic blank_slot;
  logic wr_slot;

  assign accept     = wr_valid && wr_ready_q;
  assign rd_slot    = pix_ce && disp_active;
  assign blank_slot = pix_ce && !disp_active;
  assign wr_slot    = !pix_ce && hold_full_q
                   && (!VBLANK_ONLY || vblank);

  always_comb begin
    hold_full_d  = hold_full_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    tag0_d       = TAG_IDLE;
    tag1_d       = tag0_q;
    disp_pixel_d = disp_pixel_q;
    wr_done_d    = 1'b0;
    stall_cnt_d  = stall_cnt_q;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;

    unique case (1'b1)
      rd_slot: begin
        ram_en_d   = 1'b1;
        ram_addr_d = disp_addr;
        tag0_d     = TAG_RD;
      end
      blank_slot: begin
        tag0_d = TAG_BLANK;
      end
      wr_slot: begin
        ram_en_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = hold_addr_q;
        ram_wdata_d = hold_data_q;
        wr_done_d   = 1'b1;
        hold_full_d = 1'b0;
        tag0_d      = TAG_WR;
      end
      default: ;
    endcase

    // Accept only happens while the buffer is empty, so it never races a commit.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_addr_d = wr_addr;
      hold_data_d = wr_data;
    end
    wr_ready_d = !hold_full_d;

    if (wr_valid && !wr_ready_q && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;

    unique case (tag1_q)
      TAG_RD:    disp_pixel_d = ram_rdata;
      TAG_BLANK: disp_pixel_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ready_q   <= 1'b0;
      hold_full_q  <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      tag0_q       <= TAG_IDLE;
      tag1_q       <= TAG_IDLE;
      disp_pixel_q <= '0;
      wr_done_q    <= 1'b0;
      stall_cnt_q  <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      wr_ready_q   <= wr_ready_d;
      hold_full_q  <= hold_full_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      tag0_q       <= tag0_d;
      tag1_q       <= tag1_d;
      disp_pixel_q <= disp_pixel_d;
      wr_done_q    <= wr_done_d;
      stall_cnt_q  <= stall_cnt_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign disp_pixel = disp_pixel_q;
  assign wr_done    = wr_done_q;
  assign stall_cnt  = stall_cnt_q;
  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;

endmodule
